// File: rtl/ccff_bitstream_loader.sv
// ============================================================================
// ccff_bitstream_loader
// ----------------------------------------------------------------------------
// Upstream feeder for the grid configuration chain.
//
// It accepts bitstream words over a valid/ready stream and shifts them out
// MSB first onto ccff_head. ccff_en is the clock enable for the chain. A load
// shifts exactly CHAIN_LEN bits. From the last word, only the top
// (CHAIN_LEN mod WORD_W) bits are used. After the load the loader raises done.
//
// Optional feature macro: CCFF_VERIFY_EN
//   When defined, the loader keeps the XOR parity of every bit it shifts in.
//   After the load it recirculates the chain once: ccff_head follows
//   ccff_tail for CHAIN_LEN enabled cycles. It XORs the tail bits and
//   compares the result with the stored parity. A mismatch raises err.
//   When undefined, there is no verify pass and err is tied to 0.
//
// Ports
//   prog_clk   in   configuration clock, all state on the rising edge
//   pReset     in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a load (ignored while busy)
//   cfg_data   in   bitstream word [WORD_W-1:0], shifted out MSB first
//   cfg_valid  in   cfg_data is valid
//   cfg_ready  out  high only while fetching a word
//   ccff_head  out  serial bit into the chain head
//   ccff_en    out  chain clock enable
//   ccff_tail  in   serial bit from the chain tail
//   busy       out  load or verify in progress
//   done       out  load complete; held until the next accepted start
//   err        out  verify parity mismatch; held until the next start
// ============================================================================
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef CCFF_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd3;
`endif

    logic [2:0]        state_reg,     state_next;
    logic [WORD_W-1:0] sreg_reg,      sreg_next;
    logic [WCNT_W-1:0] word_cnt_reg,  word_cnt_next;   // bits of current word still to emit
    logic [CNT_W-1:0]  bits_left_reg, bits_left_next;  // chain bits (or verify cycles) left
    logic              en_reg,        en_next;
    logic              head_reg,      head_next;
    // Low for the first edge after reset release, so a start pulse in the
    // same cycle as the release is ignored.
    logic              armed_reg;
`ifdef CCFF_VERIFY_EN
    logic              par_reg,       par_next;        // parity of bits shifted in
    logic              chk_reg,       chk_next;        // parity of tail bits seen in verify
    logic              err_reg,       err_next;
`endif

    always_comb begin
        state_next     = state_reg;
        sreg_next      = sreg_reg;
        word_cnt_next  = word_cnt_reg;
        bits_left_next = bits_left_reg;
        en_next        = 1'b0;
        head_next      = head_reg;
`ifdef CCFF_VERIFY_EN
        par_next       = par_reg;
        chk_next       = chk_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start && armed_reg) begin
                    state_next     = ST_FETCH;
                    bits_left_next = CNT_W'(CHAIN_LEN);
`ifdef CCFF_VERIFY_EN
                    par_next       = 1'b0;
                    chk_next       = 1'b0;
                    err_next       = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                if (cfg_valid) begin
                    state_next = ST_SHIFT;
                    sreg_next  = cfg_data;
                    // A final partial word emits only the bits the chain still needs.
                    word_cnt_next = (32'(bits_left_reg) >= WORD_W) ? WCNT_W'(WORD_W)
                                                                   : WCNT_W'(bits_left_reg);
                    // Head and enable are registered, so the first bit is
                    // presented in the cycle right after the handshake.
                    en_next    = 1'b1;
                    head_next  = cfg_data[WORD_W-1];
                end
            end
            ST_SHIFT: begin
                // Each SHIFT cycle presents one bit, and the chain takes it
                // at the edge that ends the cycle.
                sreg_next      = sreg_reg << 1;
                word_cnt_next  = word_cnt_reg - WCNT_W'(1);
                bits_left_next = bits_left_reg - CNT_W'(1);
`ifdef CCFF_VERIFY_EN
                par_next       = par_reg ^ head_reg;
`endif
                if (bits_left_reg == CNT_W'(1)) begin
`ifdef CCFF_VERIFY_EN
                    state_next     = ST_VERIFY;
                    bits_left_next = CNT_W'(CHAIN_LEN);
                    chk_next       = 1'b0;
                    en_next        = 1'b1;
`else
                    state_next     = ST_DONE;
`endif
                end else if (word_cnt_reg == WCNT_W'(1)) begin
                    state_next = ST_FETCH;
                end else begin
                    en_next    = 1'b1;
                    head_next  = sreg_next[WORD_W-1];
                end
            end
`ifdef CCFF_VERIFY_EN
            ST_VERIFY: begin
                chk_next       = chk_reg ^ ccff_tail;
                bits_left_next = bits_left_reg - CNT_W'(1);
                if (bits_left_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    err_next   = (chk_next != par_reg);
                end else begin
                    en_next    = 1'b1;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_reg     <= ST_IDLE;
            sreg_reg      <= '0;
            word_cnt_reg  <= '0;
            bits_left_reg <= '0;
            en_reg        <= 1'b0;
            head_reg      <= 1'b0;
            armed_reg     <= 1'b0;
`ifdef CCFF_VERIFY_EN
            par_reg       <= 1'b0;
            chk_reg       <= 1'b0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            sreg_reg      <= sreg_next;
            word_cnt_reg  <= word_cnt_next;
            bits_left_reg <= bits_left_next;
            en_reg        <= en_next;
            head_reg      <= head_next;
            armed_reg     <= 1'b1;
`ifdef CCFF_VERIFY_EN
            par_reg       <= par_next;
            chk_reg       <= chk_next;
            err_reg       <= err_next;
`endif
        end
    end

    assign cfg_ready = (state_reg == ST_FETCH);
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign ccff_en   = en_reg;

`ifdef CCFF_VERIFY_EN
    // During verify the chain recirculates, so the head follows the tail
    // combinationally and the chain contents are preserved.
    assign ccff_head = (state_reg == ST_VERIFY) ? ccff_tail : head_reg;
    assign err       = err_reg;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_reg;
    assign err         = 1'b0;
`endif

endmodule
